simproc_dbg_ctrl: RTL and testbench
===================================

// Module: simproc_dbg_ctrl
// PURPOSE
//  Host-side debug/load controller for the simproc core. Turns a byte command stream
//  (valid/ready) into program load/readback, PC set, and run/step/halt sequencing.
//  Owns the single asynchronous-read 8x256 program memory port, muxed between host and core.
// PARAMETERS
//  ACK_CODE  8'h00  rsp_data for a successful non-read command
//  ERR_CODE  8'hEE  rsp_data for a rejected command (no side effects)
// PORTS
//  clk           in   1  clock
//  rst           in   1  synchronous reset, active-high (same rst as core)
//  cmd_valid     in   1  host command valid
//  cmd_ready     out  1  command accepted when cmd_valid & cmd_ready
//  cmd_op        in   3  0 NOP, 1 SET_ADDR, 2 WRITE, 3 READ, 4 SET_PC, 5 RUN, 6 HALT, 7 STATUS
//  cmd_data      in   8  command operand
//  rsp_valid     out  1  response valid; held until rsp_ready
//  rsp_ready     in   1  host accepts response
//  rsp_data      out  8  response byte
//  core_mem_addr in   8  core memory address
//  core_mem_din  in   8  core write data
//  core_mem_we   in   1  core write enable
//  mem_addr      out  8  to memory
//  mem_din       out  8  to memory
//  mem_we        out  1  to memory
//  mem_dout      in   8  memory async read data (also wired to core)
//  core_pc_val   out  8  to core pc_set_val
//  core_pc_wr    out  1  to core pc_set_wr
//  core_run      out  1  to core run
//  core_halt     in   1  core halt (core in IDLE)
//  core_done     in   1  core done (instruction retired)
//  busy          out  1  controller not in C_IDLE
// BEHAVIOUR
//  - States: C_IDLE, C_START, C_RUN, C_STOP. Reset: C_IDLE, addr_ptr=0, remain=0,
//    retired=0, rsp_valid=0, rsp_data=0; outputs: core_run=0, core_pc_wr=0, mem_we=0, busy=0.
//  - cmd_ready = (C_IDLE|C_RUN) & ~rsp_valid. One outstanding response; accepted cmd sets
//    rsp_valid next cycle (except HALT in C_RUN, see below).
//  - Memory ownership: host iff C_IDLE & core_halt; else mem_* = core_mem_* passthrough.
//    Host-owned idle cycles drive mem_we=0, mem_addr=addr_ptr.
//  - C_IDLE commands (combinational side effects in accept cycle):
//    NOP -> ACK. SET_ADDR -> addr_ptr<=data, ACK.
//    WRITE -> mem_addr=addr_ptr, mem_din=data, mem_we=1; addr_ptr++ (0xFF wraps to 0x00); ACK.
//    READ -> rsp_data<=mem_dout @ addr_ptr; addr_ptr++ (wrap).
//    SET_PC -> core_pc_val=data, core_pc_wr=1 one cycle; ACK.
//    RUN -> ACK; remain<=data, limited<=(data!=0), retired<=0; go C_START.
//    HALT -> ACK (already halted). STATUS -> rsp_data=retired.
//  - C_RUN commands: NOP, SET_ADDR, STATUS as above; HALT -> C_STOP, no immediate rsp;
//    WRITE/READ/SET_PC/RUN -> ERR_CODE, no side effect (addr_ptr unchanged).
//  - core_run = C_START | (C_RUN & ~(limited & remain==1)). Never combinational from core_done.
//  - C_START: one cycle, core sees run in its IDLE -> C_RUN.
//  - C_RUN: on core_done: retired++ (saturate 0xFF); if limited: remain--, and if remain==1
//    -> C_STOP (core_run already 0, core returns to IDLE).
//  - C_STOP: core_run=0; core_done still counted in retired; when core_halt=1 -> C_IDLE;
//    if entered via HALT, issue ACK on that transition.
//  - RUN data=1 is single-step: core_run high exactly one cycle, one instruction.
//  - HALT mid-instruction: current instruction completes, no new fetch.
//  - Reset mid-run: all state to reset values immediately; core reset concurrently.
// TESTING
//  1 SET_ADDR 10, WRITE A1, WRITE B2, SET_ADDR 10, READ, READ -> rsp 00,00,00,00,A1,B2
//  2 SET_ADDR FF, WRITE 55, WRITE 66 -> mem[FF]=55, mem[00]=66, addr_ptr=01
//  3 load 4x ADD at 0, SET_PC 00, RUN 03 -> exactly 3 core_done pulses, halt=1, STATUS -> 03
//  4 RUN 01 -> core_run high 1 cycle, one core_done, core PC=01, busy drops after halt
//  5 RUN 00 (loop program), WRITE 77 -> rsp EE, mem unchanged; HALT -> ACK only after core_halt=1
//  6 assert rst during C_RUN -> next cycle core_run=0, rsp_valid=0, cmd_ready=1, addr_ptr=00

Source files
------------

// File: rtl/simproc_dbg_ctrl_if.sv
// Host command/response channel of the simproc debug controller.
// The host drives commands and accepts responses (master); the controller
// accepts commands and produces one response per command (slave).
interface simproc_dbg_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;

   modport master (
      output cmd_valid, cmd_op, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/simproc_dbg_ctrl.sv
// Host-side debug/load controller for the simproc core.
// Decodes a byte command stream into program load/readback, PC set and
// run/step/halt sequencing, and owns the shared program memory port.
module simproc_dbg_ctrl #(
   parameter logic [7:0] ACK_CODE = 8'h00,
   parameter logic [7:0] ERR_CODE = 8'hEE
) (
   input  logic                      clk,
   input  logic                      rst,
   simproc_dbg_ctrl_if.slave         host,
   input  logic [7:0]                core_mem_addr_i,
   input  logic [7:0]                core_mem_din_i,
   input  logic                      core_mem_we_i,
   output logic [7:0]                mem_addr_o,
   output logic [7:0]                mem_din_o,
   output logic                      mem_we_o,
   input  logic [7:0]                mem_dout_i,
   output logic [7:0]                core_pc_val_o,
   output logic                      core_pc_wr_o,
   output logic                      core_run_o,
   input  logic                      core_halt_i,
   input  logic                      core_done_i,
   output logic                      busy_o
);

   typedef enum logic [1:0] {
      C_IDLE  = 2'd0,
      C_START = 2'd1,
      C_RUN   = 2'd2,
      C_STOP  = 2'd3
   } state_t;

   localparam logic [2:0] OP_NOP      = 3'd0;
   localparam logic [2:0] OP_SET_ADDR = 3'd1;
   localparam logic [2:0] OP_WRITE    = 3'd2;
   localparam logic [2:0] OP_READ     = 3'd3;
   localparam logic [2:0] OP_SET_PC   = 3'd4;
   localparam logic [2:0] OP_RUN      = 3'd5;
   localparam logic [2:0] OP_HALT     = 3'd6;
   localparam logic [2:0] OP_STATUS   = 3'd7;

   state_t     state_q, state_d;
   logic [7:0] addr_ptr_q, addr_ptr_d;
   logic [7:0] remain_q, remain_d;
   logic       limited_q, limited_d;
   logic [7:0] retired_q, retired_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [7:0] rsp_data_q, rsp_data_d;
   logic       halt_pend_q, halt_pend_d;

   logic       cmd_ready_s;
   logic       accept_s;
   logic       host_own_s;

   // Retired-instruction counter sticks at 0xFF instead of wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      sat_inc = (v == 8'hFF) ? v : (v + 8'd1);
   endfunction

   assign cmd_ready_s    = ((state_q == C_IDLE) || (state_q == C_RUN)) && !rsp_valid_q;
   assign accept_s       = host.cmd_valid && cmd_ready_s;
   assign host_own_s     = (state_q == C_IDLE) && core_halt_i;
   assign host.cmd_ready = cmd_ready_s;
   assign host.rsp_valid = rsp_valid_q;
   assign host.rsp_data  = rsp_data_q;
   assign busy_o         = (state_q != C_IDLE);

   // State and datapath registers; rst returns everything to the idle state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= C_IDLE;
         addr_ptr_q  <= 8'h00;
         remain_q    <= 8'h00;
         limited_q   <= 1'b0;
         retired_q   <= 8'h00;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_ptr_q  <= addr_ptr_d;
         remain_q    <= remain_d;
         limited_q   <= limited_d;
         retired_q   <= retired_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         halt_pend_q <= halt_pend_d;
      end
   end

   // Next-state, command decode, memory mux and core control.
   always_comb begin
      state_d       = state_q;
      addr_ptr_d    = addr_ptr_q;
      remain_d      = remain_q;
      limited_d     = limited_q;
      retired_d     = retired_q;
      rsp_data_d    = rsp_data_q;
      halt_pend_d   = halt_pend_q;
      core_pc_val_o = host.cmd_data;
      core_pc_wr_o  = 1'b0;
      core_run_o    = 1'b0;

      // Host only touches memory while the core is parked; otherwise the core owns it.
      if (host_own_s) begin
         mem_addr_o = addr_ptr_q;
         mem_din_o  = host.cmd_data;
         mem_we_o   = 1'b0;
      end else begin
         mem_addr_o = core_mem_addr_i;
         mem_din_o  = core_mem_din_i;
         mem_we_o   = core_mem_we_i;
      end

      if (rsp_valid_q && host.rsp_ready) begin
         rsp_valid_d = 1'b0;
      end else begin
         rsp_valid_d = rsp_valid_q;
      end

      case (state_q)
         C_IDLE: begin
            if (accept_s) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = ACK_CODE;
               case (host.cmd_op)
                  OP_SET_ADDR: addr_ptr_d = host.cmd_data;
                  OP_WRITE: begin
                     mem_we_o   = host_own_s;
                     addr_ptr_d = addr_ptr_q + 8'd1;
                  end
                  OP_READ: begin
                     rsp_data_d = mem_dout_i;
                     addr_ptr_d = addr_ptr_q + 8'd1;
                  end
                  OP_SET_PC:  core_pc_wr_o = 1'b1;
                  OP_RUN: begin
                     remain_d  = host.cmd_data;
                     limited_d = (host.cmd_data != 8'd0);
                     retired_d = 8'h00;
                     state_d   = C_START;
                  end
                  OP_STATUS:  rsp_data_d = retired_q;
                  default:    rsp_data_d = ACK_CODE;
               endcase
            end else begin
               state_d = C_IDLE;
            end
         end

         C_START: begin
            core_run_o = 1'b1;
            state_d    = C_RUN;
         end

         C_RUN: begin
            // Drop run before the last counted instruction retires so no new fetch starts.
            core_run_o = !(limited_q && (remain_q == 8'd1));
            if (core_done_i) begin
               retired_d = sat_inc(retired_q);
               if (limited_q) begin
                  remain_d = remain_q - 8'd1;
                  if (remain_q == 8'd1) begin
                     state_d = C_STOP;
                  end else begin
                     state_d = C_RUN;
                  end
               end else begin
                  remain_d = remain_q;
               end
            end else begin
               retired_d = retired_q;
            end
            if (accept_s) begin
               rsp_valid_d = (host.cmd_op != OP_HALT);
               case (host.cmd_op)
                  OP_NOP:      rsp_data_d = ACK_CODE;
                  OP_SET_ADDR: begin
                     addr_ptr_d = host.cmd_data;
                     rsp_data_d = ACK_CODE;
                  end
                  OP_STATUS:   rsp_data_d = retired_q;
                  OP_HALT: begin
                     halt_pend_d = 1'b1;
                     state_d     = C_STOP;
                  end
                  default:     rsp_data_d = ERR_CODE;
               endcase
            end else begin
               halt_pend_d = halt_pend_q;
            end
         end

         C_STOP: begin
            if (core_done_i) begin
               retired_d = sat_inc(retired_q);
            end else begin
               retired_d = retired_q;
            end
            if (core_halt_i) begin
               state_d = C_IDLE;
               if (halt_pend_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = ACK_CODE;
                  halt_pend_d = 1'b0;
               end else begin
                  halt_pend_d = 1'b0;
               end
            end else begin
               state_d = C_STOP;
            end
         end

         default: state_d = C_IDLE;
      endcase
   end

endmodule

// File: tb/tb_simproc_dbg_ctrl.sv
// Self-checking bench for simproc_dbg_ctrl with a small memory and core model.
module tb_simproc_dbg_ctrl;
   localparam logic [2:0] OP_NOP = 3'd0, OP_SET_ADDR = 3'd1, OP_WRITE = 3'd2, OP_READ = 3'd3;
   localparam logic [2:0] OP_SET_PC = 3'd4, OP_RUN = 3'd5, OP_HALT = 3'd6, OP_STATUS = 3'd7;
   localparam logic [7:0] ACK = 8'h00, ERR = 8'hEE;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   simproc_dbg_ctrl_if bus();

   logic [7:0] core_mem_addr, core_mem_din, mem_addr, mem_din, mem_dout, core_pc_val;
   logic       core_mem_we, mem_we, core_pc_wr, core_run, core_halt, core_done, busy;

   simproc_dbg_ctrl dut (
      .clk(clk), .rst(rst), .host(bus),
      .core_mem_addr_i(core_mem_addr), .core_mem_din_i(core_mem_din), .core_mem_we_i(core_mem_we),
      .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_we_o(mem_we), .mem_dout_i(mem_dout),
      .core_pc_val_o(core_pc_val), .core_pc_wr_o(core_pc_wr), .core_run_o(core_run),
      .core_halt_i(core_halt), .core_done_i(core_done), .busy_o(busy)
   );

   // Program memory: asynchronous read, synchronous write.
   logic [7:0] mem [0:255];
   assign mem_dout = mem[mem_addr];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      end else if (mem_we) begin
         mem[mem_addr] <= mem_din;
      end
   end

   // Core model: IDLE -> FETCH -> EXEC (done). Opcode bit7 = jump to bits[6:0], else pc+1.
   typedef enum logic [1:0] {K_IDLE, K_FETCH, K_EXEC} kstate_t;
   kstate_t    k_q;
   logic [7:0] pc_q, ir_q;
   assign core_halt     = (k_q == K_IDLE);
   assign core_done     = (k_q == K_EXEC);
   assign core_mem_addr = pc_q;
   assign core_mem_din  = 8'h00;
   assign core_mem_we   = 1'b0;
   always @(posedge clk) begin
      if (rst) begin
         k_q <= K_IDLE; pc_q <= 8'h00; ir_q <= 8'h00;
      end else begin
         case (k_q)
            K_IDLE: begin
               if (core_pc_wr) pc_q <= core_pc_val;
               if (core_run) k_q <= K_FETCH;
            end
            K_FETCH: begin ir_q <= mem_dout; k_q <= K_EXEC; end
            K_EXEC: begin
               pc_q <= ir_q[7] ? {1'b0, ir_q[6:0]} : (pc_q + 8'd1);
               k_q  <= core_run ? K_FETCH : K_IDLE;
            end
            default: k_q <= K_IDLE;
         endcase
      end
   end

   // Event counters for core_done pulses and core_run-high cycles.
   int done_cnt = 0;
   int run_cnt  = 0;
   always @(posedge clk) begin
      if (core_done) done_cnt <= done_cnt + 1;
      if (core_run)  run_cnt  <= run_cnt + 1;
   end

   // Scoreboard: expected response pushed on send, observed response pushed on arrival.
   logic [7:0] exp_q[$];
   logic [8:0] got_q[$];
   logic       halt_at_rsp;
   int         n_checks = 0;
   int         n_fail   = 0;

   task automatic do_cmd(input logic [2:0] op, input logic [7:0] data, input logic [7:0] exp);
      int n;
      exp_q.push_back(exp);
      bus.cmd_op = op; bus.cmd_data = data; bus.cmd_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.cmd_ready && n < 200) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      n = 0;
      while (!bus.rsp_valid && n < 400) begin @(negedge clk); n++; end
      if (bus.rsp_valid) begin
         got_q.push_back({1'b0, bus.rsp_data});
         halt_at_rsp   = core_halt;
         bus.rsp_ready = 1'b1;
         @(posedge clk); #1;
         bus.rsp_ready = 1'b0;
      end else begin
         got_q.push_back(9'h100);
      end
   endtask

   task automatic wait_idle(output logic ok);
      int n = 0;
      while (busy && n < 500) begin @(posedge clk); #1; n++; end
      ok = !busy;
   endtask

   task automatic test_reset;
      logic [7:0] e; logic [8:0] g;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b expected 0", bus.rsp_valid); end
      n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b expected 1", bus.cmd_ready); end
      n_checks++; if ({busy, core_run, mem_we, core_pc_wr} !== 4'b0000) begin n_fail++; $display("FAIL reset_outputs got %b expected 0000", {busy, core_run, mem_we, core_pc_wr}); end
      n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr_ptr got %h expected 00", mem_addr); end
      // Response must be held while rsp_ready stays low.
      bus.cmd_op = OP_NOP; bus.cmd_data = 8'h00; bus.cmd_valid = 1'b1;
      @(posedge clk); #1 bus.cmd_valid = 1'b0;
      repeat (3) @(posedge clk); #1;
      n_checks++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b10) begin n_fail++; $display("FAIL rsp_hold got valid/ready %b expected 10", {bus.rsp_valid, bus.cmd_ready}); end
      bus.rsp_ready = 1'b1; @(posedge clk); #1 bus.rsp_ready = 1'b0;
      do_cmd(OP_STATUS, 8'h00, 8'h00);
      do_cmd(OP_HALT, 8'h00, ACK);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
         if (g !== {1'b0, e}) begin n_fail++; $display("FAIL idle_rsp got %h expected %h", g, e); end
      end
   endtask

   task automatic test_load_readback;
      logic [7:0] e; logic [8:0] g;
      do_cmd(OP_SET_ADDR, 8'h10, ACK);
      do_cmd(OP_WRITE, 8'hA1, ACK);
      do_cmd(OP_WRITE, 8'hB2, ACK);
      do_cmd(OP_SET_ADDR, 8'h10, ACK);
      do_cmd(OP_READ, 8'h00, 8'hA1);
      do_cmd(OP_READ, 8'h00, 8'hB2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
         if (g !== {1'b0, e}) begin n_fail++; $display("FAIL load_rsp got %h expected %h", g, e); end
      end
      n_checks++; if (mem[8'h11] !== 8'hB2) begin n_fail++; $display("FAIL load_mem11 got %h expected b2", mem[8'h11]); end
   endtask

   task automatic test_wrap;
      logic [7:0] e; logic [8:0] g;
      do_cmd(OP_SET_ADDR, 8'hFF, ACK);
      do_cmd(OP_WRITE, 8'h55, ACK);
      do_cmd(OP_WRITE, 8'h66, ACK);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
         if (g !== {1'b0, e}) begin n_fail++; $display("FAIL wrap_rsp got %h expected %h", g, e); end
      end
      n_checks++; if (mem[8'hFF] !== 8'h55) begin n_fail++; $display("FAIL wrap_memFF got %h expected 55", mem[8'hFF]); end
      n_checks++; if (mem[8'h00] !== 8'h66) begin n_fail++; $display("FAIL wrap_mem00 got %h expected 66", mem[8'h00]); end
      n_checks++; if (mem_addr !== 8'h01) begin n_fail++; $display("FAIL wrap_addr_ptr got %h expected 01", mem_addr); end
   endtask

   task automatic test_run_limited;
      logic [7:0] e; logic [8:0] g; logic ok; int d0;
      do_cmd(OP_SET_ADDR, 8'h00, ACK);
      for (int i = 0; i < 4; i++) do_cmd(OP_WRITE, 8'h01, ACK);
      do_cmd(OP_SET_PC, 8'h00, ACK);
      d0 = done_cnt;
      do_cmd(OP_RUN, 8'h03, ACK);
      wait_idle(ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL run3_idle got busy=%b expected 0", busy); end
      repeat (4) @(posedge clk); #1;
      n_checks++; if (done_cnt - d0 != 3) begin n_fail++; $display("FAIL run3_done got %0d expected 3", done_cnt - d0); end
      n_checks++; if (core_halt !== 1'b1) begin n_fail++; $display("FAIL run3_halt got %b expected 1", core_halt); end
      n_checks++; if (pc_q !== 8'h03) begin n_fail++; $display("FAIL run3_pc got %h expected 03", pc_q); end
      do_cmd(OP_STATUS, 8'h00, 8'h03);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
         if (g !== {1'b0, e}) begin n_fail++; $display("FAIL run3_rsp got %h expected %h", g, e); end
      end
   endtask

   task automatic test_single_step;
      logic [7:0] e; logic [8:0] g; logic ok; int d0, r0;
      do_cmd(OP_SET_PC, 8'h00, ACK);
      d0 = done_cnt; r0 = run_cnt;
      do_cmd(OP_RUN, 8'h01, ACK);
      wait_idle(ok);
      n_checks++; if ({ok, core_halt} !== 2'b11) begin n_fail++; $display("FAIL step_idle got idle/halt %b expected 11", {ok, core_halt}); end
      repeat (3) @(posedge clk); #1;
      n_checks++; if (run_cnt - r0 != 1) begin n_fail++; $display("FAIL step_run_cycles got %0d expected 1", run_cnt - r0); end
      n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL step_done got %0d expected 1", done_cnt - d0); end
      n_checks++; if (pc_q !== 8'h01) begin n_fail++; $display("FAIL step_pc got %h expected 01", pc_q); end
      do_cmd(OP_STATUS, 8'h00, 8'h01);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
         if (g !== {1'b0, e}) begin n_fail++; $display("FAIL step_rsp got %h expected %h", g, e); end
      end
   endtask

   task automatic test_run_reject_halt;
      logic [7:0] e; logic [8:0] g; logic [7:0] snap [0:255]; int diffs;
      do_cmd(OP_SET_ADDR, 8'h00, ACK);
      do_cmd(OP_WRITE, 8'h01, ACK);
      do_cmd(OP_WRITE, 8'h80, ACK);
      do_cmd(OP_SET_PC, 8'h00, ACK);
      do_cmd(OP_RUN, 8'h00, ACK);
      repeat (5) @(posedge clk); #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL loop_busy got %b expected 1", busy); end
      for (int i = 0; i < 256; i++) snap[i] = mem[i];
      do_cmd(OP_WRITE, 8'h77, ERR);
      do_cmd(OP_READ, 8'h00, ERR);
      do_cmd(OP_SET_PC, 8'h05, ERR);
      do_cmd(OP_RUN, 8'h02, ERR);
      do_cmd(OP_NOP, 8'h00, ACK);
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== snap[i]) diffs++;
      n_checks++; if (diffs != 0) begin n_fail++; $display("FAIL loop_mem_unchanged got %0d changed bytes expected 0", diffs); end
      do_cmd(OP_HALT, 8'h00, ACK);
      n_checks++; if (halt_at_rsp !== 1'b1) begin n_fail++; $display("FAIL halt_ack_timing got core_halt=%b expected 1", halt_at_rsp); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL halt_busy got %b expected 0", busy); end
      n_checks++; if (mem_addr !== 8'h02) begin n_fail++; $display("FAIL loop_addr_ptr got %h expected 02", mem_addr); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
         if (g !== {1'b0, e}) begin n_fail++; $display("FAIL loop_rsp got %h expected %h", g, e); end
      end
   endtask

   task automatic test_reset_mid_run;
      logic [7:0] e; logic [8:0] g;
      do_cmd(OP_RUN, 8'h00, ACK);
      do_cmd(OP_SET_ADDR, 8'h42, ACK);
      repeat (3) @(posedge clk); #1;
      n_checks++; if ({busy, core_run} !== 2'b11) begin n_fail++; $display("FAIL midrun_active got busy/run %b expected 11", {busy, core_run}); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
         if (g !== {1'b0, e}) begin n_fail++; $display("FAIL midrun_rsp got %h expected %h", g, e); end
      end
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      n_checks++; if (core_run !== 1'b0) begin n_fail++; $display("FAIL rst_run got %b expected 0", core_run); end
      n_checks++; if ({bus.rsp_valid, bus.cmd_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL rst_handshake got valid/ready/busy %b expected 010", {bus.rsp_valid, bus.cmd_ready, busy}); end
      n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL rst_addr_ptr got %h expected 00", mem_addr); end
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_data = 8'h00; bus.rsp_ready = 1'b0;
      halt_at_rsp = 1'b0;
      rst = 1'b1;
      test_reset();
      test_load_readback();
      test_wrap();
      test_run_limited();
      test_single_step();
      test_run_reject_halt();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t expected test completion", $time);
      $fatal(1, "watchdog");
   end
endmodule
